// File: rtl/control_unit_if.sv
// control_unit_if: instruction-fetch and datapath control bus of control_unit.
// The step input exists only when CTRL_STEP_EN is defined.
interface control_unit_if #(parameter int PC_WIDTH = 5);
    logic [15:0]         instr_data;
    logic [PC_WIDTH-1:0] pc_out;
    logic [15:0]         ir_out;
    logic [3:0]          state_o;
    logic [7:0]          d_addr;
    logic                d_wr;
    logic                rf_s;
    logic [3:0]          rf_w_addr;
    logic                rf_w_wr;
    logic [3:0]          rf_ra_addr;
    logic [3:0]          rf_rb_addr;
    logic                rf_ra_rd;
    logic                rf_rb_rd;
    logic [2:0]          alu_s0;
`ifdef CTRL_STEP_EN
    logic                step;
`endif

    modport master (
`ifdef CTRL_STEP_EN
        input  step,
`endif
        input  instr_data,
        output pc_out, ir_out, state_o, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
        output rf_ra_addr, rf_rb_addr, rf_ra_rd, rf_rb_rd, alu_s0
    );

    modport slave (
`ifdef CTRL_STEP_EN
        output step,
`endif
        output instr_data,
        input  pc_out, ir_out, state_o, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
        input  rf_ra_addr, rf_rb_addr, rf_ra_rd, rf_rb_rd, alu_s0
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencing fetch/decode/execute of a 16-bit ISA.
// Define CTRL_STEP_EN to make FETCH wait for the step input (single-step mode).
module control_unit #(
    parameter int PC_WIDTH = 5
) (
    input logic clock,
    input logic reset,
    control_unit_if.master bus
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    logic [3:0]          state, state_nxt, dec_state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic                go, fetch, is_load, is_alu, is_st;

`ifdef CTRL_STEP_EN
    assign go = bus.step;
`else
    assign go = 1'b1;
`endif

    assign fetch = (state == S_FETCH) && go;

    always_comb begin
        dec_state = ir[15:12] == 4'h1 ? S_STORE  :
                    ir[15:12] == 4'h2 ? S_LOAD_A :
                    ir[15:12] == 4'h3 ? S_ADD    :
                    ir[15:12] == 4'h4 ? S_SUB    :
                    ir[15:12] == 4'h5 ? S_HALT   : S_NOOP;
        state_nxt = state == S_INIT   ? S_FETCH :
                    state == S_FETCH  ? (go ? S_DECODE : S_FETCH) :
                    state == S_DECODE ? dec_state :
                    state == S_LOAD_A ? S_LOAD_B :
                    state == S_HALT   ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) pc <= '0;
            if (fetch) begin
                ir <= bus.instr_data;
                pc <= pc + 1'b1;
            end
        end
    end

    // Moore decode: every control output depends only on state and ir
    assign is_load = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign is_alu  = (state == S_ADD) || (state == S_SUB);
    assign is_st   = (state == S_STORE);

    assign bus.pc_out     = pc;
    assign bus.ir_out     = ir;
    assign bus.state_o    = state;
    assign bus.d_addr     = is_load ? ir[11:4] : is_st ? ir[7:0] : 8'h00;
    assign bus.d_wr       = is_st;
    assign bus.rf_s       = is_load;
    assign bus.rf_w_addr  = (is_load || is_alu) ? ir[3:0] : 4'h0;
    assign bus.rf_w_wr    = (state == S_LOAD_B) || is_alu;
    assign bus.rf_ra_addr = (is_st || is_alu) ? ir[11:8] : 4'h0;
    assign bus.rf_ra_rd   = is_st || is_alu;
    assign bus.rf_rb_addr = is_alu ? ir[7:4] : 4'h0;
    assign bus.rf_rb_rd   = is_alu;
    assign bus.alu_s0     = state == S_ADD ? 3'b001 : state == S_SUB ? 3'b010 : 3'b000;
endmodule
